// File: rtl/rom_dl_packer.sv
// rtl/rom_dl_packer.sv - ioctl byte-to-word packer and toggle-handshake SDRAM write issuer
// Merges even/odd byte pairs into word writes; rom_loaded rises only after the last write is acked.
module rom_dl_packer #(
  parameter int         ADDR_W     = 22,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ROM_INDEX  = 8'h00
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_downl,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic [1:0]        ram_ds,
  output logic              ram_we,
  output logic              busy,
  output logic              rom_loaded,
  output logic              overflow
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int AW1 = ADDR_W + 1;
  localparam int EW  = ADDR_W + 18;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic           wr_q;
  logic           downl_q;
  logic           acc_q;
  logic           dl_rise_q;
  logic           dl_fall_q;
  logic [AW1-1:0] acc_addr;
  logic [7:0]     acc_byte;

  logic           pend_v;
  logic [AW1-1:0] pend_addr;
  logic [7:0]     pend_byte;
  logic           flush_req;
  logic           dl_done;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic           fifo_empty;
  logic           fifo_full;

  logic           is_pair;
  logic           push;
  logic           push_ok;
  logic           pop;
  logic [EW-1:0]  push_entry;
  logic [EW-1:0]  lone_entry;
  logic [EW-1:0]  pair_entry;

  state_t         state;
  state_t         state_n;

  logic           unused_addr;
  assign unused_addr = ^ioctl_addr;

  // Input stage: edges are detected here and acted on one cycle later.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q      <= 1'b0;
      downl_q   <= 1'b0;
      acc_q     <= 1'b0;
      dl_rise_q <= 1'b0;
      dl_fall_q <= 1'b0;
      acc_addr  <= '0;
      acc_byte  <= '0;
    end else begin
      wr_q      <= ioctl_wr;
      downl_q   <= ioctl_downl;
      acc_q     <= ioctl_wr & ~wr_q & ioctl_downl & (ioctl_index == ROM_INDEX);
      dl_rise_q <= ioctl_downl & ~downl_q;
      dl_fall_q <= ~ioctl_downl & downl_q;
      if (ioctl_wr && !wr_q) begin
        acc_addr <= ioctl_addr[ADDR_W:0];
        acc_byte <= ioctl_dout;
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  // A lone byte is duplicated onto both lanes; ds selects the real one.
  assign lone_entry = {pend_addr[ADDR_W:1], pend_byte, pend_byte,
                       pend_addr[0] ? 2'b10 : 2'b01};
  assign pair_entry = {pend_addr[ADDR_W:1], acc_byte, pend_byte, 2'b11};
  assign is_pair    = pend_v & ~pend_addr[0] & (acc_addr == pend_addr + AW1'(1));

  always_comb begin
    push       = 1'b0;
    push_entry = lone_entry;
    if (dl_rise_q) begin
      push = 1'b0;
    end else if (acc_q) begin
      if (is_pair) begin
        push       = 1'b1;
        push_entry = pair_entry;
      end else if (pend_v) begin
        push = 1'b1;
      end
    end else if (flush_req && pend_v) begin
      push = 1'b1;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push & (~fifo_full | pop);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_byte <= '0;
      flush_req <= 1'b0;
      dl_done   <= 1'b0;
      overflow  <= 1'b0;
    end else if (dl_rise_q) begin
      pend_v    <= 1'b0;
      flush_req <= 1'b0;
      dl_done   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (acc_q) begin
        if (push && !push_ok) begin
          overflow <= 1'b1;
        end else if (is_pair) begin
          pend_v <= 1'b0;
        end else begin
          pend_v    <= 1'b1;
          pend_addr <= acc_addr;
          pend_byte <= acc_byte;
        end
      end else if (flush_req) begin
        if (!pend_v) begin
          flush_req <= 1'b0;
        end else if (push_ok) begin
          pend_v <= 1'b0;
        end
      end
      if (dl_fall_q) begin
        flush_req <= 1'b1;
        dl_done   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem[wptr] <= push_entry;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ram_ack == ram_req) begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

  // Requesting as ~ram_ack keeps the toggle handshake valid whatever ack was left at.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_req  <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_ds   <= '0;
    end else if (pop) begin
      {ram_addr, ram_din, ram_ds} <= mem[rptr];
      ram_req <= ~ram_ack;
      ram_we  <= 1'b1;
    end else if (state == S_WAIT && ram_ack == ram_req) begin
      ram_we <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_loaded <= 1'b0;
    end else if (dl_rise_q) begin
      rom_loaded <= 1'b0;
    end else if (dl_done && !flush_req && !pend_v && fifo_empty &&
                 state == S_IDLE && !ram_we) begin
      rom_loaded <= 1'b1;
    end
  end

  assign busy = pend_v | ~fifo_empty | ram_we;

endmodule

// File: tb/tb_rom_dl_packer.sv
// tb/tb_rom_dl_packer.sv - self-checking bench for rom_dl_packer
module tb_rom_dl_packer;

  localparam int ADDR_W = 22;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_downl;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ram_req;
  logic              ram_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic [1:0]        ram_ds;
  logic              ram_we;
  logic              busy;
  logic              rom_loaded;
  logic              overflow;

  rom_dl_packer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .ROM_INDEX(8'h00)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ioctl_downl(ioctl_downl),
    .ioctl_index(ioctl_index),
    .ioctl_wr   (ioctl_wr),
    .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout),
    .ram_req    (ram_req),
    .ram_ack    (ram_ack),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_ds     (ram_ds),
    .ram_we     (ram_we),
    .busy       (busy),
    .rom_loaded (rom_loaded),
    .overflow   (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] w_addr[$];
  logic [15:0]       w_din[$];
  logic [1:0]        w_ds[$];
  int                toggles = 0;
  int                acks    = 0;
  bit                ack_hold  = 1'b0;
  int                ack_delay = 3;
  bit                ack_force = 1'b0;
  bit                ack_force_val = 1'b0;

  typedef struct {
    logic [24:0] a0;
    logic [7:0]  d0;
    logic [24:0] a1;
    logic [7:0]  d1;
    int          n;
    logic [39:0] w0;
    logic [39:0] w1;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] word_at(input int idx);
    if (idx < w_addr.size()) return {w_addr[idx], w_din[idx], w_ds[idx]};
    return '1;
  endfunction

  // Records every issued write on the rising edge of ram_we.
  initial begin : monitor
    logic prev_we;
    logic prev_req;
    prev_we  = 1'b0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset_n && ram_we && !prev_we) begin
        w_addr.push_back(ram_addr);
        w_din.push_back(ram_din);
        w_ds.push_back(ram_ds);
      end
      if (reset_n && ram_req != prev_req) toggles++;
      prev_we  = ram_we;
      prev_req = ram_req;
    end
  end

  // SDRAM side: acks an outstanding request after ack_delay cycles.
  initial begin : responder
    int cnt;
    cnt     = 0;
    ram_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ack_force) begin
        ram_ack = ack_force_val;
        cnt     = 0;
      end else if (!ack_hold && ram_we && ram_req != ram_ack) begin
        cnt++;
        if (cnt >= ack_delay) begin
          ram_ack = ram_req;
          cnt     = 0;
          acks++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
    tick(gap);
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_downl = 1'b1;
    tick(4);
  endtask

  task automatic dl_end();
    ioctl_downl = 1'b0;
    tick(1);
  endtask

  task automatic wait_loaded(input string name, input int ack_target);
    bit seen;
    bit early;
    seen  = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk_sys);
      if (rom_loaded) begin
        seen = 1'b1;
        if (acks < ack_target) early = 1'b1;
      end
    end
    check({name, "_rom_loaded"}, seen, 1);
    check({name, "_loaded_before_ack"}, early, 0);
  endtask

  task automatic wait_we(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_sys);
      if (ram_we) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  initial begin : main
    vec_t vt[6];
    int   wb;
    int   tb0;
    int   ab;
    bit   seen;

    vt[0] = '{25'h100, 8'h11, 25'h101, 8'h22, 1, {22'h80, 16'h2211, 2'b11}, 40'h0};
    vt[1] = '{25'h201, 8'hA5, 25'h204, 8'h5A, 2, {22'h100, 16'hA5A5, 2'b10}, {22'h102, 16'h5A5A, 2'b01}};
    vt[2] = '{25'h301, 8'h33, 25'h302, 8'h44, 2, {22'h180, 16'h3333, 2'b10}, {22'h181, 16'h4444, 2'b01}};
    vt[3] = '{25'h400, 8'h55, 25'h402, 8'h66, 2, {22'h200, 16'h5555, 2'b01}, {22'h201, 16'h6666, 2'b01}};
    vt[4] = '{25'h105, 8'h77, 25'h104, 8'h88, 2, {22'h82, 16'h7777, 2'b10}, {22'h82, 16'h8888, 2'b01}};
    vt[5] = '{25'h7FFFFE, 8'h12, 25'h7FFFFF, 8'h34, 1, {22'h3FFFFF, 16'h3412, 2'b11}, 40'h0};

    reset_n     = 1'b0;
    ioctl_downl = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    tick(3);
    check("reset_outputs", {ram_req, ram_we, ram_addr, ram_din, ram_ds, busy, rom_loaded, overflow}, 0);
    reset_n = 1'b1;
    tick(2);

    ack_delay = 3;
    for (int v = 0; v < 6; v++) begin
      wb  = w_addr.size();
      tb0 = toggles;
      ab  = acks;
      dl_start(8'h00);
      send_byte(vt[v].a0, vt[v].d0, 2);
      send_byte(vt[v].a1, vt[v].d1, 2);
      dl_end();
      wait_loaded($sformatf("vec%0d", v), ab + vt[v].n);
      check($sformatf("vec%0d_nwrites", v), w_addr.size() - wb, vt[v].n);
      check($sformatf("vec%0d_toggles", v), toggles - tb0, vt[v].n);
      check($sformatf("vec%0d_word0", v), word_at(wb), vt[v].w0);
      if (vt[v].n == 2) check($sformatf("vec%0d_word1", v), word_at(wb + 1), vt[v].w1);
      check($sformatf("vec%0d_busy_idle", v), busy, 0);
    end

    // 16 consecutive bytes, slow SDRAM.
    ack_delay = 40;
    wb = w_addr.size();
    ab = acks;
    dl_start(8'h00);
    for (int i = 0; i < 16; i++) send_byte(25'(25'h2000 + i), 8'(8'h10 + i), 30);
    dl_end();
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk_sys);
      if (acks == ab + 7 && ram_we) seen = 1'b1;
    end
    check("slow_last_outstanding", seen, 1);
    check("slow_busy_before_last_ack", busy, 1);
    wait_loaded("slow", ab + 8);
    check("slow_nwrites", w_addr.size() - wb, 8);
    check("slow_overflow", overflow, 0);
    check("slow_busy_after", busy, 0);
    for (int k = 0; k < 8; k++)
      check($sformatf("slow_word%0d", k), word_at(wb + k),
            {22'(22'h1000 + k), 8'(8'h11 + 2 * k), 8'(8'h10 + 2 * k), 2'b11});

    // FIFO overflow with ack held off.
    ack_hold = 1'b1;
    wb = w_addr.size();
    ab = acks;
    dl_start(8'h00);
    for (int i = 0; i < 12; i++) send_byte(25'(25'h1000 + 2 * i), 8'(8'hC0 + i), (i % 2 == 1) ? 4 : 1);
    tick(5);
    check("ovf_flag", overflow, 1);
    check("ovf_issued_one", w_addr.size() - wb, 1);
    dl_end();
    tick(20);
    check("ovf_not_loaded_yet", rom_loaded, 0);
    check("ovf_busy_held", busy, 1);
    ack_delay = 2;
    ack_hold  = 1'b0;
    wait_loaded("ovf", ab + 6);
    check("ovf_nwrites", w_addr.size() - wb, 6);
    check("ovf_flag_sticky", overflow, 1);
    for (int k = 0; k < 6; k++)
      check($sformatf("ovf_word%0d", k), word_at(wb + k),
            {22'(22'h800 + k), 8'(8'hC0 + k), 8'(8'hC0 + k), 2'b01});

    // Foreign index is ignored; download start clears status.
    dl_start(8'h01);
    check("idx_start_clears_loaded", rom_loaded, 0);
    check("idx_start_clears_overflow", overflow, 0);
    wb  = w_addr.size();
    tb0 = toggles;
    for (int i = 0; i < 4; i++) send_byte(25'(25'h3000 + i), 8'(i), 2);
    tick(20);
    check("idx_no_writes", w_addr.size() - wb, 0);
    check("idx_no_toggles", toggles - tb0, 0);
    check("idx_not_busy", busy, 0);
    dl_end();
    tick(10);
    ioctl_index = 8'h00;

    // Reset in WAIT with ram_ack high.
    ack_hold      = 1'b1;
    ack_force_val = 1'b1;
    ack_force     = 1'b1;
    tick(2);
    ack_force     = 1'b0;
    dl_start(8'h00);
    send_byte(25'h500, 8'hAB, 2);
    send_byte(25'h501, 8'hCD, 2);
    wait_we("rst_pre_issue");
    check("rst_pre_req_is_not_ack", ram_req, 0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outputs", {ram_req, ram_we, ram_addr, ram_din, ram_ds, busy, rom_loaded, overflow}, 0);
    ioctl_downl = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    wb = w_addr.size();
    dl_start(8'h00);
    send_byte(25'h600, 8'h01, 2);
    send_byte(25'h601, 8'h02, 2);
    dl_end();
    wait_we("rst_post_issue");
    check("rst_post_req", ram_req, 0);
    check("rst_post_word", word_at(wb), {22'h300, 16'h0201, 2'b11});
    tick(10);
    check("rst_post_waiting", ram_we, 1);
    ab = acks;
    ack_hold = 1'b0;
    wait_loaded("rst", ab + 1);
    check("rst_ack_low", ram_ack, 0);
    check("rst_we_done", ram_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_dl_packer.md
# rom_dl_packer

Byte-to-word packer and SDRAM write issuer for the ROM download path. It sits between `data_io` (ioctl byte stream) and the 16-bit SDRAM write port of the video/SDRAM block, and uses a toggle req/ack handshake on that port. It merges consecutive even/odd bytes into single word writes and buffers them in a small FIFO. It raises `rom_loaded` only after the last byte has been acknowledged by SDRAM, so the core reset can safely key off it.

## Interface
Parameters:
- `ADDR_W`, 22: SDRAM word-address width; `ram_addr = ioctl_addr[ADDR_W:1]`.
- `FIFO_DEPTH`, 4: write FIFO entries, power of two, ≥2.
- `ROM_INDEX`, 8'h00: `ioctl_index` value accepted; other indices are ignored.

Ports:
- `clk_sys` in 1: system clock (48 MHz domain). One clock; reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous active-low reset.
- `ioctl_downl` in 1: download active.
- `ioctl_index` in 8: download index.
- `ioctl_wr` in 1: byte strobe; only the rising edge is used.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ram_req` out 1: toggle request.
- `ram_ack` in 1: toggle acknowledge. A transfer is complete when `ram_ack == ram_req`.
- `ram_addr` out ADDR_W: word address of the current transfer.
- `ram_din` out 16: `{hi, lo}`. Even byte goes to `lo`, odd byte goes to `hi`. An unused lane is driven as a duplicate of the used lane.
- `ram_ds` out 2: byte enables `{hi, lo}`.
- `ram_we` out 1: high while a transfer is outstanding.
- `busy` out 1: high when a byte is pending, the FIFO is non-empty, or a transfer is outstanding.
- `rom_loaded` out 1: the download completed and all writes were acknowledged.
- `overflow` out 1: sticky; set when a byte was dropped because the FIFO was full.

## Operation
- **Accept.** A byte is accepted when the registered `ioctl_wr` rises while `ioctl_downl = 1` and `ioctl_index == ROM_INDEX`.
- **Pending register.** Holds `{addr, byte, valid}`. For each accepted byte:
  - If the pending byte is valid, its address is even, and the new address equals pending+1: push `{addr>>1, {new, pend}, ds=11}` and clear pending.
  - Otherwise, if the pending byte is valid: push it alone (even → ds=01, odd → ds=10), then load the new byte into pending.
  - Otherwise: load the new byte into pending.
  - There is at most one FIFO push per cycle.
- **Flush at end of download.** On the falling edge of `ioctl_downl`, set `flush_req`. While `flush_req` is set and pending is valid, push pending when the FIFO is not full. The flush is never dropped; it waits for FIFO space. Clear `flush_req` once pending is empty.
- **Full FIFO.** An accepted byte that needs a push while the FIFO is full is dropped, `overflow` is set, and pending is unchanged.
- **Start of download.** On the rising edge of `ioctl_downl`: clear `rom_loaded`, `overflow`, `flush_req` and pending. The FIFO is not cleared.
- **Issuer FSM.**
  - IDLE: if the FIFO is non-empty, latch the head into `ram_addr`/`ram_din`/`ram_ds`, pop it, set `ram_req <= ~ram_ack` and `ram_we <= 1`, then go to WAIT.
  - WAIT: when `ram_ack == ram_req`, set `ram_we <= 0` and go to IDLE.
  - Issuing as `~ram_ack` keeps the handshake consistent after reset, whatever `ram_ack` is.
- **rom_loaded.** Set once the download has ended and all of these hold: `flush_req` is clear, pending is empty, the FIFO is empty, and the FSM is in IDLE with `ram_we = 0`. It stays set until the next download starts.

## Timing
- **Reset values.** `ram_req = 0`, `ram_we = 0`, `ram_addr = 0`, `ram_din = 0`, `ram_ds = 0`, `busy = 0`, `rom_loaded = 0`, `overflow = 0`. The FIFO, pending register and `flush_req` are empty; the FSM is in IDLE.
- **Input edge detect.** One register stage on `ioctl_wr` and `ioctl_downl`. A byte is processed in the cycle after its rising edge is seen.
- **Push to request.** A push in cycle N reaches the FIFO in N+1; `ram_req` toggles in N+2 at the earliest (FSM in IDLE).
- **Throughput.** One transfer is outstanding at a time. The next issue happens one cycle after the cycle in which the ack matched.
- **Simultaneous push and pop** in the same cycle are allowed, including when the FIFO is full: the pop frees the slot and the push is accepted.
- **rom_loaded latency.** `rom_loaded` rises one cycle after its set conditions become true.
- **Reset mid-transfer.** Everything is abandoned. After reset, the first issue drives `ram_req = ~ram_ack`.

## Test plan
- **Pair merge.** Bytes 0x11 at address 0x100 and 0x22 at 0x101 → one write, `ram_addr = 0x80`, `ram_din = 0x2211`, `ds = 11`, one `ram_req` toggle.
- **Lone bytes.** Bytes at 0x201 and then 0x204, then download end → writes `{0x100, ds=10}` and `{0x102, ds=01}`; `rom_loaded` rises only after the second ack.
- **Slow ack.** Stream 16 consecutive bytes with ack delayed 40 cycles → 8 word writes in address order, `overflow = 0`, `busy` high until the last ack.
- **Overflow.** FIFO_DEPTH=4, ack held off, 12 bytes with alternating gaps → `overflow = 1`. The dropped byte is never written. The end-of-download flush still lands.
- **Index filter and restart.** Bytes with `ioctl_index = 1` → no requests. A second download start clears `rom_loaded` and `overflow`.
- **Reset with ack high.** Assert `reset_n` low mid-WAIT with `ram_ack = 1` → all outputs at their reset values. The next transfer drives `ram_req = 0`, and the FSM completes when `ram_ack` toggles to 0.
